// File: rtl/cal_rdata_decoder.sv
// cal_rdata_decoder
//   Routes in-order memory read returns to the CPU or accelerator port,
//   using a DEPTH-entry FIFO of one-bit owner tags captured at issue time.
//   Optional macro CAL_RD_ERR_EN adds a sticky protocol-error flag (err);
//   when it is undefined, err is tied low.
//   Owner encodings come from cal_head.v; they are defined locally here only
//   when that header has not already been read.

`ifndef ARB_CPU
`define ARB_CPU 1'b0
`endif
`ifndef ARB_ACC
`define ARB_ACC 1'b1
`endif

module cal_rdata_decoder #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arb_res,
  input  logic          rd_issue,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          acc_rvalid,
  output logic [DW-1:0] acc_rdata,
  output logic          busy,
  output logic          full,
  output logic          err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_FULL
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic [DEPTH-1:0] owner_q;
  logic             push;
  logic             pop;
  logic             head_owner;

  // Accept/pop decisions and the next occupancy; a pop in FULL frees the slot a same-cycle push uses.
  always_comb begin
    pop        = mem_rvalid && (state_q != ST_IDLE);
    push       = rd_issue && ((state_q != ST_FULL) || pop);
    head_owner = owner_q[rd_ptr_q];
    cnt_d      = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (cnt_d == '0) begin
      state_d = ST_IDLE;
    end else if (cnt_d == DEPTH_C) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PEND;
    end
  end

  // Owner FIFO, occupancy state and registered routing of returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      owner_q    <= '0;
      busy       <= 1'b0;
      full       <= 1'b0;
      cpu_rvalid <= 1'b0;
      acc_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      acc_rdata  <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= arb_res;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      busy       <= (state_d != ST_IDLE);
      full       <= (state_d == ST_FULL);
      cpu_rvalid <= pop && (head_owner == `ARB_CPU);
      acc_rvalid <= pop && (head_owner == `ARB_ACC);
      if (pop && (head_owner == `ARB_CPU)) begin
        cpu_rdata <= mem_rdata;
      end
      if (pop && (head_owner == `ARB_ACC)) begin
        acc_rdata <= mem_rdata;
      end
    end
  end

`ifdef CAL_RD_ERR_EN
  // Sticky error: dropped issue while full, or a return with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((rd_issue && (state_q == ST_FULL) && !pop) ||
                 (mem_rvalid && (state_q == ST_IDLE))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cal_rdata_decoder.sv
// Self-checking bench for cal_rdata_decoder (DW=16, DEPTH=4) against a
// queue-based reference model of outstanding read owners.

`ifndef ARB_CPU
`define ARB_CPU 1'b0
`endif
`ifndef ARB_ACC
`define ARB_ACC 1'b1
`endif

module tb_cal_rdata_decoder;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int OW    = 2*DW + 5;
`ifdef CAL_RD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          arb_res;
  logic          rd_issue;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          acc_rvalid;
  logic [DW-1:0] acc_rdata;
  logic          busy;
  logic          full;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            mq[$];
  logic          exp_cv, exp_av, exp_busy, exp_full, exp_err;
  logic [DW-1:0] exp_cd, exp_ad;

  logic [OW-1:0] dut_vec;
  assign dut_vec = {cpu_rvalid, cpu_rdata, acc_rvalid, acc_rdata, busy, full, err};

  cal_rdata_decoder #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_res   (arb_res),
    .rd_issue  (rd_issue),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .acc_rvalid(acc_rvalid),
    .acc_rdata (acc_rdata),
    .busy      (busy),
    .full      (full),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] exp_vec();
    return {exp_cv, exp_cd, exp_av, exp_ad, exp_busy, exp_full, exp_err};
  endfunction

  task automatic model_clear();
    mq.delete();
    exp_cv = 0; exp_av = 0; exp_busy = 0; exp_full = 0; exp_err = 0;
    exp_cd = '0; exp_ad = '0;
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic step(input logic is, input logic own, input logic rv, input logic [DW-1:0] d);
    int sz;
    bit p, u, o;
    rd_issue = is; arb_res = own; mem_rvalid = rv; mem_rdata = d;
    sz = mq.size();
    p  = rv && (sz > 0);
    u  = is && ((sz < DEPTH) || p);
    if (ERR_EN && ((is && !u) || (rv && (sz == 0)))) exp_err = 1'b1;
    exp_cv = 1'b0;
    exp_av = 1'b0;
    if (p) begin
      o = mq.pop_front();
      if (o == `ARB_CPU) begin exp_cv = 1'b1; exp_cd = d; end
      else begin exp_av = 1'b1; exp_ad = d; end
    end
    if (u) mq.push_back(own);
    exp_busy = (mq.size() != 0);
    exp_full = (mq.size() == DEPTH);
    @(posedge clk);
    #1;
    rd_issue = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rd_issue = 0; mem_rvalid = 0; arb_res = 0; mem_rdata = '0;
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rd_issue = 0; mem_rvalid = 0; arb_res = 0; mem_rdata = '0;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL reset_assert: got %h expected %h", dut_vec, {OW{1'b0}});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, '0);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_routing();
    logic [DW-1:0] dat [3];
    logic          own [3];
    dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333;
    own[0] = `ARB_CPU; own[1] = `ARB_ACC; own[2] = `ARB_CPU;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, own[i], 0, '0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL routing_issue[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, dat[i]);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL routing_ret[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    step(0, 0, 0, '0);
    n_checks++;
    if ({acc_rdata, cpu_rdata, busy, cpu_rvalid, acc_rvalid} !== {16'h2222, 16'h3333, 3'b000}) begin
      n_fail++; $display("FAIL routing_hold: got acc=%h cpu=%h busy=%b expected acc=2222 cpu=3333 busy=0",
                         acc_rdata, cpu_rdata, busy);
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, `ARB_ACC, 0, '0);
    n_checks++;
    if ({busy, full, err} !== 3'b110) begin
      n_fail++; $display("FAIL full_reach: got busy/full/err=%b%b%b expected 110", busy, full, err);
    end
    step(1, `ARB_CPU, 0, '0);
    n_checks++;
    if ({full, err} !== {1'b1, ERR_EN}) begin
      n_fail++; $display("FAIL full_drop: got full/err=%b%b expected 1%b", full, err, ERR_EN);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, DW'($urandom()));
      n_checks++;
      if (dut_vec !== exp_vec() || acc_rvalid !== 1'b1) begin
        n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL full_empty: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, `ARB_ACC, 0, '0);
    step(1, `ARB_CPU, 1, 16'h5A5A);
    n_checks++;
    if ({acc_rvalid, cpu_rvalid, full, acc_rdata} !== {3'b101, 16'h5A5A} || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL simul_full: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, DW'($urandom()));
      n_checks++;
      if (dut_vec !== exp_vec() || cpu_rvalid !== (i == DEPTH-1)) begin
        n_fail++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 2; i++) step(1, 1'($urandom_range(1, 0)), 0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1'($urandom_range(1, 0)), 1, DW'($urandom()));
      n_checks++;
      if (dut_vec !== exp_vec() || (cpu_rvalid ~^ acc_rvalid)) begin
        n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, DW'($urandom()));
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL wrap_drain[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), DW'($urandom()));
      n_checks++;
      if (dut_vec !== exp_vec() || (cpu_rvalid && acc_rvalid)) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, `ARB_CPU, 0, '0);
    step(1, `ARB_ACC, 0, '0);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL midrst_issue: got %h expected %h", dut_vec, exp_vec());
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL midrst_during: got %h expected 0", dut_vec);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1, 16'hABCD);
    n_checks++;
    if ({cpu_rvalid, acc_rvalid, busy, err} !== {3'b000, ERR_EN} || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL midrst_return: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    rst_n = 1'b0; rd_issue = 0; mem_rvalid = 0; arb_res = 0; mem_rdata = '0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_routing();
    test_full_drop();
    test_full_simul();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
